// File: rtl/pipe_fwd_ctrl.sv
// Decode-stage forwarding/interlock scheduler: tracks EX/MEM destinations, registers
// the ALU operand-source selects for EX, and stalls on load-use and multiply/divide conflicts.
module pipe_fwd_ctrl #(
    parameter int MDU_CYCLES = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic       d_use_rs,
    input  logic       d_use_rt,
    input  logic       d_shift,
    input  logic       d_aluimm,
    input  logic       d_wreg,
    input  logic       d_m2reg,
    input  logic [4:0] d_rn,
    input  logic       d_jal,
    input  logic       d_mdu,
    input  logic       d_hilo,
    output logic [1:0] ea_depen,
    output logic [1:0] eb_depen,
    output logic       stall,
    output logic       mdu_start,
    output logic       mdu_busy
);
    logic [4:0] e_rn_q, e_rn_d, m_rn_q, m_rn_d;
    logic       e_wreg_q, e_wreg_d, e_m2reg_q, e_m2reg_d, m_wreg_q, m_wreg_d;
    logic [5:0] mdu_cnt_q, mdu_cnt_d;
    logic [1:0] ea_depen_q, ea_depen_d, eb_depen_q, eb_depen_d;
    logic       mdu_start_q, mdu_start_d;

    logic [4:0] rn_eff;
    logic       hit_e_rs, hit_e_rt, hit_m_rs, hit_m_rt, lu, mc;

    always_comb begin
        rn_eff   = d_jal ? 5'd31 : d_rn;
        hit_e_rs = e_wreg_q && (e_rn_q == d_rs) && (d_rs != 5'd0);
        hit_e_rt = e_wreg_q && (e_rn_q == d_rt) && (d_rt != 5'd0);
        hit_m_rs = m_wreg_q && (m_rn_q == d_rs) && (d_rs != 5'd0);
        hit_m_rt = m_wreg_q && (m_rn_q == d_rt) && (d_rt != 5'd0);
        lu = e_m2reg_q && ((d_use_rs && !d_shift && hit_e_rs) ||
                           (d_use_rt && !d_aluimm && hit_e_rt));
        mc = mdu_busy && (d_mdu || d_hilo);
    end

    assign stall     = lu || mc;
    assign mdu_busy  = (mdu_cnt_q != 6'd0);
    assign ea_depen  = ea_depen_q;
    assign eb_depen  = eb_depen_q;
    assign mdu_start = mdu_start_q;

    always_comb begin
        // E tracker beats M tracker: the youngest producer supplies the value.
        if (d_shift)                    ea_depen_d = 2'd1;
        else if (d_use_rs && hit_e_rs)  ea_depen_d = 2'd2;
        else if (d_use_rs && hit_m_rs)  ea_depen_d = 2'd3;
        else                            ea_depen_d = 2'd0;
        if (d_aluimm)                   eb_depen_d = 2'd1;
        else if (d_use_rt && hit_e_rt)  eb_depen_d = 2'd2;
        else if (d_use_rt && hit_m_rt)  eb_depen_d = 2'd3;
        else                            eb_depen_d = 2'd0;

        m_rn_d      = e_rn_q;
        m_wreg_d    = e_wreg_q;
        mdu_cnt_d   = (mdu_cnt_q != 6'd0) ? mdu_cnt_q - 6'd1 : mdu_cnt_q;
        e_rn_d      = rn_eff;
        e_wreg_d    = d_wreg;
        e_m2reg_d   = d_m2reg;
        mdu_start_d = d_mdu;

        if (stall) begin
            // Bubble into EX; the counter keeps running so the stall can resolve.
            e_wreg_d    = 1'b0;
            e_m2reg_d   = 1'b0;
            ea_depen_d  = 2'd0;
            eb_depen_d  = 2'd0;
            mdu_start_d = 1'b0;
        end else if (d_mdu) begin
            mdu_cnt_d = 6'(MDU_CYCLES);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e_rn_q      <= 5'd0;
            e_wreg_q    <= 1'b0;
            e_m2reg_q   <= 1'b0;
            m_rn_q      <= 5'd0;
            m_wreg_q    <= 1'b0;
            mdu_cnt_q   <= 6'd0;
            ea_depen_q  <= 2'd0;
            eb_depen_q  <= 2'd0;
            mdu_start_q <= 1'b0;
        end else begin
            e_rn_q      <= e_rn_d;
            e_wreg_q    <= e_wreg_d;
            e_m2reg_q   <= e_m2reg_d;
            m_rn_q      <= m_rn_d;
            m_wreg_q    <= m_wreg_d;
            mdu_cnt_q   <= mdu_cnt_d;
            ea_depen_q  <= ea_depen_d;
            eb_depen_q  <= eb_depen_d;
            mdu_start_q <= mdu_start_d;
        end
    end
endmodule

// File: tb/tb_pipe_fwd_ctrl.sv
// Bench for pipe_fwd_ctrl: directed scenarios with literal expectations, then random
// instruction streams checked every cycle against a behavioural pipeline model.
module tb_pipe_fwd_ctrl;
    localparam int N = 4;

    logic       clock = 1'b0, reset = 1'b1;
    logic [4:0] d_rs, d_rt, d_rn;
    logic       d_use_rs, d_use_rt, d_shift, d_aluimm, d_wreg, d_m2reg, d_jal, d_mdu, d_hilo;
    logic [1:0] ea_depen, eb_depen;
    logic       stall, mdu_start, mdu_busy;

    pipe_fwd_ctrl #(.MDU_CYCLES(N)) dut (
        .clock(clock), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_shift(d_shift), .d_aluimm(d_aluimm),
        .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_rn(d_rn), .d_jal(d_jal), .d_mdu(d_mdu),
        .d_hilo(d_hilo), .ea_depen(ea_depen), .eb_depen(eb_depen), .stall(stall),
        .mdu_start(mdu_start), .mdu_busy(mdu_busy)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    bit chk_on = 1'b0;

    // Model: destination of the writer currently in EX / MEM (0 = none), whether the
    // EX writer is a load, and the absolute cycle at which the multiply/divide finishes.
    int m_edst, m_mdst, cyc, busy_until;
    bit m_eload;
    int exp_ea, exp_eb;
    bit exp_start, exp_stall;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            chk("stall", int'(stall), int'(exp_stall));
            chk("ea_depen", int'(ea_depen), exp_ea);
            chk("eb_depen", int'(eb_depen), exp_eb);
            chk("mdu_start", int'(mdu_start), int'(exp_start));
            chk("mdu_busy", int'(mdu_busy), int'(cyc < busy_until));
        end
    end

    function automatic bit mdl_stall();
        bit lu, mc;
        lu = m_eload && m_edst != 0 &&
             ((d_use_rs && !d_shift && int'(d_rs) == m_edst) ||
              (d_use_rt && !d_aluimm && int'(d_rt) == m_edst));
        mc = (cyc < busy_until) && (d_mdu || d_hilo);
        return lu || mc;
    endfunction

    function automatic int mdl_sel(input bit imm, input bit use_r, input int r);
        if (imm) return 1;
        if (use_r && r != 0 && r == m_edst) return 2;
        if (use_r && r != 0 && r == m_mdst) return 3;
        return 0;
    endfunction

    task automatic mdl_reset();
        m_edst = 0; m_mdst = 0; m_eload = 0; busy_until = cyc;
        exp_ea = 0; exp_eb = 0; exp_start = 0;
    endtask

    task automatic mdl_edge();
        bit st;
        int na, nb;
        st = mdl_stall();
        na = mdl_sel(d_shift, d_use_rs, int'(d_rs));
        nb = mdl_sel(d_aluimm, d_use_rt, int'(d_rt));
        cyc++;
        m_mdst = m_edst;
        if (st) begin
            m_edst = 0; m_eload = 0; exp_ea = 0; exp_eb = 0; exp_start = 0;
        end else begin
            m_edst  = d_wreg ? (d_jal ? 31 : int'(d_rn)) : 0;
            m_eload = d_m2reg;
            exp_ea = na; exp_eb = nb; exp_start = d_mdu;
            if (d_mdu) busy_until = cyc + N;
        end
    endtask

    task automatic ins(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic sh, input logic imm, input logic wr,
                       input logic m2, input logic [4:0] rn, input logic jal,
                       input logic mdu, input logic hilo);
        d_rs = rs; d_rt = rt; d_use_rs = urs; d_use_rt = urt; d_shift = sh; d_aluimm = imm;
        d_wreg = wr; d_m2reg = m2; d_rn = rn; d_jal = jal; d_mdu = mdu; d_hilo = hilo;
        #1;
    endtask

    task automatic nop();
        ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rn);
        ins(rs, rt, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, rn, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        exp_stall = mdl_stall();
        @(negedge clock);
        @(posedge clock);
        mdl_edge();
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        #1;
        mdl_reset();
        exp_stall = mdl_stall();
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        cyc = 0;
        mdl_reset();
        nop();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk_on = 1'b1;
        chk("rst_stall", int'(stall), 0);
        chk("rst_ea", int'(ea_depen), 0);
        chk("rst_eb", int'(eb_depen), 0);
        chk("rst_busy", int'(mdu_busy), 0);

        add(5'd1, 5'd2, 5'd3); step();
        chk("empty_ea", int'(ea_depen), 0); chk("empty_eb", int'(eb_depen), 0);

        add(5'd1, 5'd2, 5'd5); step();
        add(5'd5, 5'd5, 5'd6); step();
        chk("fwdE_ea", int'(ea_depen), 2); chk("fwdE_eb", int'(eb_depen), 2);

        add(5'd1, 5'd2, 5'd5); step();
        nop(); step();
        add(5'd5, 5'd5, 5'd6); step();
        chk("fwdM_ea", int'(ea_depen), 3); chk("fwdM_eb", int'(eb_depen), 3);

        ins(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0); step();
        add(5'd4, 5'd0, 5'd7);
        chk("lu_stall", int'(stall), 1);
        step();
        chk("lu_bub_ea", int'(ea_depen), 0); chk("lu_bub_eb", int'(eb_depen), 0);
        chk("lu_once", int'(stall), 0);
        step();
        chk("lu_ea", int'(ea_depen), 3); chk("lu_eb", int'(eb_depen), 0);

        ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); step();
        ins(5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0); step();
        chk("jal_ea", int'(ea_depen), 2); chk("jal_eb", int'(eb_depen), 1);
        ins(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0); step();
        chk("sll_ea", int'(ea_depen), 1); chk("sll_eb", int'(eb_depen), 2);
        add(5'd1, 5'd1, 5'd0); step();
        add(5'd0, 5'd0, 5'd9); step();
        chk("r0_ea", int'(ea_depen), 0); chk("r0_eb", int'(eb_depen), 0);

        ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step();
        chk("mul_start", int'(mdu_start), 1); chk("mul_busy", int'(mdu_busy), 1);
        ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) begin
            chk("mfhi_stall", int'(stall), 1);
            chk("mfhi_busy", int'(mdu_busy), 1);
            step();
            chk("mul_pulse", int'(mdu_start), 0);
        end
        chk("mfhi_go", int'(stall), 0); chk("mfhi_idle", int'(mdu_busy), 0);
        step();

        ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step();
        ins(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0); step();
        ins(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("both_stall", int'(stall), 1); chk("both_busy", int'(mdu_busy), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_stall", int'(stall), 0); chk("rst_mid_busy", int'(mdu_busy), 0);
        mdl_reset();
        exp_stall = 1'b0;
        @(negedge clock); @(posedge clock);
        #1 reset = 1'b0;
        add(5'd4, 5'd5, 5'd3); step();
        chk("resume_ea", int'(ea_depen), 0); chk("resume_eb", int'(eb_depen), 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                reset_pulse();
            end else if (!exp_stall || $urandom_range(0, 7) == 0) begin
                ins(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                    1'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom), 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 11) == 0),
                    1'($urandom_range(0, 11) == 0));
            end
            step();
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
